// File: rtl/pixel_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pixel_sequencer_pkg
//   Shared definitions for the pixel sequencer: pixel width, default frame
//   geometry and the sequencer state encoding. Imported by pixel_sequencer
//   and pixel_watchdog.
// ----------------------------------------------------------------------------
package pixel_sequencer_pkg;

    // Width of one pixel as seen by the ROMs, the register file and the
    // frame buffer.
    localparam int PIXEL_W = 12;

    // Width of the processor result register; only the low PIXEL_W bits
    // carry the output pixel.
    localparam int REGOUT_W = 32;

    // Default frame geometry (320x240).
    localparam int FRAME_WIDTH        = 320;
    localparam int FRAME_HEIGHT       = 240;
    localparam int DEFAULT_NUM_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

    // Smallest address width that covers the default frame.
    localparam int DEFAULT_ADDR_W = 17;

    // Default watchdog limit, in cycles spent waiting for the processor.
    localparam int DEFAULT_TIMEOUT = 4096;

    // Per-pixel sequence. CLEAR waits out a stale done, FETCH drives the ROM
    // address, LOAD captures the ROM data, WAIT_DONE hands the pixel to the
    // processor, WRITE strobes the frame buffer, FINISH flags the frame end.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        FETCH     = 3'd2,
        LOAD      = 3'd3,
        WAIT_DONE = 3'd4,
        WRITE     = 3'd5,
        FINISH    = 3'd6
    } seq_state_t;

endpackage : pixel_sequencer_pkg

// File: rtl/pixel_watchdog.sv
// ----------------------------------------------------------------------------
// pixel_watchdog
//   Counts consecutive cycles for which `run` is high and raises `expired`
//   in the cycle where TIMEOUT cycles have elapsed. Dropping `run` clears the
//   count, so every pixel gets a fresh budget. Only instantiated by
//   pixel_sequencer when PIXEL_SEQ_WATCHDOG_EN is defined.
// ----------------------------------------------------------------------------
module pixel_watchdog
    import pixel_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    // Wide enough to hold TIMEOUT itself, which also keeps TIMEOUT=1 legal.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count cycles spent waiting; restart whenever the wait ends.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LAST_COUNT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // The count is 0 in the first waiting cycle, so hitting LAST_COUNT means
    // this is the TIMEOUT-th cycle without an answer.
    assign expired = run && (wait_cnt == LAST_COUNT);

endmodule : pixel_watchdog

// File: rtl/pixel_sequencer.sv
// ----------------------------------------------------------------------------
// pixel_sequencer
//   Frame-level driver for the watermark soft processor. For every pixel
//   address it reads the image and watermark ROMs, presents the pixel pair to
//   the register file, raises `waiting`, holds until the processor program
//   signals `done`, then writes regout[11:0] to the output frame buffer.
//
//   Optional feature (macro PIXEL_SEQ_WATCHDOG_EN):
//     When defined, a pixel_watchdog bounds the time spent in WAIT_DONE. On
//     expiry the loaded image pixel is written to the frame buffer instead of
//     the processor result and the sticky `timeout_err` flag is set (cleared
//     only by `rst`). When undefined, WAIT_DONE waits indefinitely and
//     `timeout_err` is tied low.
//
//   NUM_PIXELS must not exceed 2**ADDR_W.
// ----------------------------------------------------------------------------
module pixel_sequencer
    import pixel_sequencer_pkg::*;
#(
    parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PIXEL_W-1:0]  image_data,
    input  logic [PIXEL_W-1:0]  water_data,
    output logic [PIXEL_W-1:0]  imagein,
    output logic [PIXEL_W-1:0]  waterin,
    output logic                waiting,
    input  logic                done,
    input  logic [REGOUT_W-1:0] regout,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [PIXEL_W-1:0]  fb_data,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    seq_state_t        state;
    logic [ADDR_W-1:0] pixel_cnt;

    // The processor result register is 32 bits wide but only the low pixel
    // bits are meaningful; the rest is deliberately dropped.
    logic unused_regout_bits;
    assign unused_regout_bits = ^regout[REGOUT_W-1:PIXEL_W];

`ifdef PIXEL_SEQ_WATCHDOG_EN
    logic wd_expired;

    pixel_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state == WAIT_DONE),
        .expired (wd_expired)
    );
`else
    // Without the watchdog there is no way to time out.
    assign timeout_err = 1'b0;
`endif

    // Sequencer FSM: state, pixel counter and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked
        // block and is only seen on a rising edge; it still wins over every
        // state so an aborted frame produces no further write strobes.
        if (rst) begin
            state      <= IDLE;
            pixel_cnt  <= '0;
            rom_addr   <= '0;
            imagein    <= '0;
            waterin    <= '0;
            waiting    <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PIXEL_SEQ_WATCHDOG_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            // NOTE: the one-cycle strobes default low every cycle and are only
            // raised by the state that owns them; using <= throughout means
            // every branch sees the register values from before this edge.
            fb_we      <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        pixel_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                end

                // A done left high from the previous pixel (or frame) must
                // drop before the next pixel is handed out.
                CLEAR: begin
                    if (!done) begin
                        rom_addr <= pixel_cnt;
                        state    <= FETCH;
                    end
                end

                // ROM address is on the bus this cycle; data follows next.
                FETCH: begin
                    state <= LOAD;
                end

                LOAD: begin
                    imagein <= image_data;
                    waterin <= water_data;
                    waiting <= 1'b1;
                    state   <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (done) begin
                        fb_addr <= pixel_cnt;
                        fb_data <= regout[PIXEL_W-1:0];
                        fb_we   <= 1'b1;
                        waiting <= 1'b0;
                        state   <= WRITE;
                    end
`ifdef PIXEL_SEQ_WATCHDOG_EN
                    // No answer in time: pass the image pixel through so the
                    // frame stays complete, and remember that it happened.
                    else if (wd_expired) begin
                        fb_addr     <= pixel_cnt;
                        fb_data     <= imagein;
                        fb_we       <= 1'b1;
                        waiting     <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= WRITE;
                    end
`endif
                end

                // fb_we is high during this state; pick the next pixel or end.
                WRITE: begin
                    if (pixel_cnt == LAST_ADDR) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= FINISH;
                    end else begin
                        pixel_cnt <= pixel_cnt + ADDR_W'(1);
                        state     <= CLEAR;
                    end
                end

                // frame_done is high during this state.
                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : pixel_sequencer

// File: tb/tb_pixel_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pixel_sequencer
//   Self-checking bench for pixel_sequencer with a 4-pixel frame. A table of
//   per-pixel records (processor result, answer delay, optional mid-frame
//   start pulse, expected frame-buffer data) drives the main flow; short
//   hand-written sequences cover start timing, stale done, reset abort and,
//   when PIXEL_SEQ_WATCHDOG_EN is defined, the watchdog pass-through.
// ----------------------------------------------------------------------------
module tb_pixel_sequencer;

    localparam int NUM_PIXELS = 4;
    localparam int ADDR_W     = 4;
    localparam int TIMEOUT    = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       image_data;
    logic [11:0]       water_data;
    logic [11:0]       imagein;
    logic [11:0]       waterin;
    logic              waiting;
    logic              done;
    logic [31:0]       regout;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [11:0]       fb_data;
    logic              busy;
    logic              frame_done;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    logic rom_force = 1'b0;

    typedef struct {
        logic [31:0] regout;
        int          delay;
        bit          pulse_start;
        logic [11:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    pixel_sequencer #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rom_addr    (rom_addr),
        .image_data  (image_data),
        .water_data  (water_data),
        .imagein     (imagein),
        .waterin     (waterin),
        .waiting     (waiting),
        .done        (done),
        .regout      (regout),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs: image pixel = address, watermark = address ^ 0xA50.
    always @(posedge clk) begin
        image_data <= rom_force ? 12'h5A5 : {8'h00, rom_addr};
        water_data <= {8'h00, rom_addr} ^ 12'hA50;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse start for one sampled edge; returns at the negedge after it.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) until waiting is high at a negedge.
    task automatic wait_waiting();
        int n = 0;
        while (waiting !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("waiting_seen", {31'd0, waiting}, 32'd1);
    endtask

    // Run one pixel from the table: check the presented pair, answer after
    // the record's delay, check the write strobe and the frame end.
    task automatic run_pixel(input int i);
        vec_t v;
        int   idx;
        v   = vecs[i];
        idx = i % NUM_PIXELS;
        wait_waiting();
        check("imagein", {20'd0, imagein}, idx);
        check("waterin", {20'd0, waterin}, idx ^ 'hA50);
        if (v.pulse_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_ignored_waiting", {31'd0, waiting}, 32'd1);
        end
        for (int k = 0; k < v.delay; k++) begin
            @(negedge clk);
            check("hold_waiting", {31'd0, waiting}, 32'd1);
            check("no_early_we", {31'd0, fb_we}, 32'd0);
        end
        done   = 1'b1;
        regout = v.regout;
        @(negedge clk);
        done = 1'b0;
        check("fb_we", {31'd0, fb_we}, 32'd1);
        check("fb_addr", {28'd0, fb_addr}, idx);
        check("fb_data", {20'd0, fb_data}, {20'd0, v.exp_data});
        check("waiting_low_on_write", {31'd0, waiting}, 32'd0);
        check("timeout_err_clear", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        check("fb_we_one_cycle", {31'd0, fb_we}, 32'd0);
        if (idx == NUM_PIXELS - 1) begin
            check("frame_done", {31'd0, frame_done}, 32'd1);
            check("busy_end", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("frame_done_pulse", {31'd0, frame_done}, 32'd0);
        end else begin
            check("no_frame_done", {31'd0, frame_done}, 32'd0);
            check("busy_mid", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, {28'd0, rom_addr}, 32'd0);
        check({tag, "_imagein"}, {20'd0, imagein}, 32'd0);
        check({tag, "_waterin"}, {20'd0, waterin}, 32'd0);
        check({tag, "_waiting"}, {31'd0, waiting}, 32'd0);
        check({tag, "_fb_we"}, {31'd0, fb_we}, 32'd0);
        check({tag, "_fb_addr"}, {28'd0, fb_addr}, 32'd0);
        check({tag, "_fb_data"}, {20'd0, fb_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    // Absolute bound on the whole run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        // Frame A: result = index ^ 0xFFF with junk upper bits.
        vecs[0]  = '{32'h0000_0FFF, 0, 1'b0, 12'hFFF};
        vecs[1]  = '{32'hFFFF_FFFE, 1, 1'b0, 12'hFFE};
        vecs[2]  = '{32'h1234_5FFD, 2, 1'b0, 12'hFFD};
        vecs[3]  = '{32'h8000_0FFC, 3, 1'b0, 12'hFFC};
        // Frame B: stale done at start, upper-bit masking, start mid-frame.
        vecs[4]  = '{32'hABCD_E123, 0, 1'b0, 12'h123};
        vecs[5]  = '{32'h0000_0000, 2, 1'b0, 12'h000};
        vecs[6]  = '{32'h5555_5555, 1, 1'b1, 12'h555};
        vecs[7]  = '{32'hFFFF_FFFF, 0, 1'b0, 12'hFFF};
        // Frame C: after a reset abort.
        vecs[8]  = '{32'h0000_0FFF, 3, 1'b0, 12'hFFF};
        vecs[9]  = '{32'h0000_0FFE, 0, 1'b0, 12'hFFE};
        vecs[10] = '{32'h0000_0FFD, 1, 1'b1, 12'hFFD};
        vecs[11] = '{32'h0000_0FFC, 2, 1'b0, 12'hFFC};

        rst    = 1'b1;
        start  = 1'b0;
        done   = 1'b0;
        regout = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Frame A with exact start-up timing.
        pulse_start();
        check("c1_busy", {31'd0, busy}, 32'd1);
        check("c1_waiting", {31'd0, waiting}, 32'd0);
        @(negedge clk);
        check("c2_rom_addr", {28'd0, rom_addr}, 32'd0);
        @(negedge clk);
        check("c3_waiting", {31'd0, waiting}, 32'd0);
        @(negedge clk);
        check("c4_waiting", {31'd0, waiting}, 32'd1);
        for (int i = 0; i < 4; i++) run_pixel(i);

        // Frame B: done held high at start stalls in CLEAR.
        done = 1'b1;
        pulse_start();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_waiting", {31'd0, waiting}, 32'd0);
            check("stall_fb_we", {31'd0, fb_we}, 32'd0);
            check("stall_busy", {31'd0, busy}, 32'd1);
        end
        done = 1'b0;
        @(negedge clk);
        check("resume_fetch_addr", {28'd0, rom_addr}, 32'd0);
        check("resume_c1_waiting", {31'd0, waiting}, 32'd0);
        @(negedge clk);
        check("resume_c2_waiting", {31'd0, waiting}, 32'd0);
        @(negedge clk);
        check("resume_c3_waiting", {31'd0, waiting}, 32'd1);
        for (int i = 4; i < 8; i++) run_pixel(i);

        // Reset abort in WAIT_DONE of pixel 1.
        pulse_start();
        run_pixel(8);
        wait_waiting();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_we", {31'd0, fb_we}, 32'd0);
            check("abort_idle", {31'd0, busy | waiting}, 32'd0);
        end
        pulse_start();
        for (int i = 8; i < 12; i++) run_pixel(i);

`ifdef PIXEL_SEQ_WATCHDOG_EN
        // Processor never answers: image pixel passes through after TIMEOUT.
        rom_force = 1'b1;
        pulse_start();
        wait_waiting();
        check("wd_imagein", {20'd0, imagein}, 32'h5A5);
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
            check("wd_no_early_we", {31'd0, fb_we}, 32'd0);
        end
        @(negedge clk);
        check("wd_fb_we", {31'd0, fb_we}, 32'd1);
        check("wd_fb_data", {20'd0, fb_data}, 32'h5A5);
        check("wd_fb_addr", {28'd0, fb_addr}, 32'd0);
        check("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
        wait_waiting();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wd_sticky", {31'd0, timeout_err}, 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wd_reset_clears", {31'd0, timeout_err}, 32'd0);
`else
        @(negedge clk);
        check("no_wd_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pixel_sequencer

// File: doc/pixel_sequencer.md
# pixel_sequencer

Frame-level driver for the watermark soft processor. Walks every pixel address of the image and watermark ROMs, presents each 12-bit pixel pair to the register file's image/watermark inputs, and raises `waiting`. It then holds until the processor program signals `done`, captures the 12-bit result pixel into the output frame buffer, and advances to the next pixel. It sits directly upstream of the register file inputs and directly downstream of its `regout`/`done` outputs.

## Interface
Parameters:
- NUM_PIXELS, 76800, pixels per frame (320x240)
- ADDR_W, 17, pixel address width; must satisfy 2^ADDR_W >= NUM_PIXELS
- TIMEOUT, 4096, watchdog limit in cycles (used only with `PIXEL_SEQ_WATCHDOG_EN`)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- rom_addr  out  ADDR_W  address to image and watermark ROMs (shared)
- image_data  in  12  image ROM pixel, valid 1 cycle after `rom_addr`
- water_data  in  12  watermark ROM pixel, valid 1 cycle after `rom_addr`
- imagein  out  12  image pixel to register file ($t4)
- waterin  out  12  watermark pixel to register file ($t5)
- waiting  out  1  pixel presented, processor may run ($s6 bit 0)
- done  in  1  processor finished pixel ($t7 bit 0)
- regout  in  32  processor result ($t6); bits [11:0] used
- fb_we  out  1  frame buffer write strobe, one cycle
- fb_addr  out  ADDR_W  frame buffer write address
- fb_data  out  12  frame buffer write data
- busy  out  1  high from accepted `start` until frame end
- frame_done  out  1  one-cycle pulse after last pixel written
- timeout_err  out  1  sticky watchdog flag (tied 0 without watchdog)

## Operation
- All outputs registered; reset value 0 for every output; state = IDLE, pixel counter = 0.
- States: IDLE, CLEAR, FETCH, LOAD, WAIT_DONE, WRITE, FINISH.
- IDLE: `start`=1 -> CLEAR, counter=0, busy=1. `start` in any other state ignored.
- CLEAR: hold until `done`=0 (rejects stale done from previous pixel/frame); then -> FETCH.
- FETCH: drive `rom_addr`=counter; -> LOAD.
- LOAD: capture `image_data`/`water_data` into `imagein`/`waterin`; set `waiting`=1; -> WAIT_DONE.
- WAIT_DONE: hold `waiting`=1 until `done`=1; then latch fb_addr=counter, fb_data=regout[11:0], -> WRITE.
- WRITE: `fb_we`=1 for exactly this cycle, `waiting`=0. If counter = NUM_PIXELS-1 -> FINISH, else counter+1 -> CLEAR.
- FINISH: `frame_done`=1 one cycle, busy=0, -> IDLE. Counter does not wrap past NUM_PIXELS-1.
- `imagein`/`waterin` hold last loaded value between pixels; upper regout bits ignored.
- `rst` in any state aborts the frame: no further `fb_we`, all outputs 0 next cycle.

## Timing
- `start` sampled cycle 0 with `done`=0: CLEAR c1, FETCH c2 (rom_addr valid), LOAD c3, `waiting`=1 visible c4.
- `done` sampled high in cycle n -> `fb_we`=1 in cycle n+1, `waiting`=0 in cycle n+1.
- Minimum per-pixel overhead excluding processor time: 5 cycles (CLEAR, FETCH, LOAD, WAIT_DONE, WRITE).
- `done` already high on entering CLEAR: stall until low; no premature write possible.

## Configuration
- `PIXEL_SEQ_WATCHDOG_EN` defined: cycle counter runs in WAIT_DONE; reaching TIMEOUT without `done` writes `image_data` pass-through (`imagein`) to the frame buffer, sets `timeout_err` (cleared only by `rst`), proceeds as normal WRITE.
- Undefined: WAIT_DONE waits indefinitely; `timeout_err` tied 0; no counter logic.

## Structure
- Shared package: state encoding, PIXEL_W=12, default frame dimensions/NUM_PIXELS.
- One sub-module natural: `pixel_watchdog` (counter + expiry compare), instantiated only under the macro.

## Test plan
- NUM_PIXELS=4, ROM = pixel index, processor model answers `done` 3 cycles after `waiting`, regout=index^0xFFF -> fb writes at addr 0..3 with 0xFFF,0xFFE,0xFFD,0xFFC; one `frame_done`.
- `done` held high at `start` for 10 cycles -> no FETCH, no `fb_we` until `done` drops; then normal flow.
- `start` pulsed mid-frame (pixel 2) -> ignored; counter and writes unaffected.
- `rst` asserted in WAIT_DONE of pixel 1 -> next cycle all outputs 0, no `fb_we`; later `start` restarts at addr 0.
- regout=0xABCD_E123 -> fb_data=0x123.
- Watchdog build, TIMEOUT=16, `done` never asserted, image pixel 0x5A5 -> fb_data=0x5A5 at cycle WAIT_DONE+16, `timeout_err`=1 stays high.
